uart_led_pwm_ctrl: RTL and testbench
====================================

// Module: uart_led_pwm_ctrl
// PURPOSE
//  Byte-command LED controller fed by the UART receiver's rxbyte/received strobe.
//  Successor to the fixed 3-LED step toggler: NUM_CH channels, per-channel PWM duty,
//  a multi-byte set-duty command with inter-byte timeout, and selectable output polarity.
//  Sits between uart_rx and the RGB driver pins in the top level.
// PARAMETERS
//  NUM_CH       3        number of LED channels (1..8)
//  PWM_BITS     8        duty/counter width; PWM period = 2**PWM_BITS clk cycles
//  TIMEOUT_CYC  1200000  max clk cycles between bytes of a multi-byte command (>=2)
//  ACTIVE_LOW   1        1: led_out driven low = LED on; 0: high = on
// PORTS
//  clk       in   1          system clock
//  rst_n     in   1          asynchronous active-low reset
//  rx_data   in   8          received byte, valid when rx_valid=1
//  rx_valid  in   1          one-cycle strobe per received byte
//  led_out   out  NUM_CH     PWM LED drive, polarity per ACTIVE_LOW
//  busy      out  1          1 while collecting payload bytes of an 'S' command
//  cmd_err   out  1          one-cycle pulse: unknown opcode or timeout abort
// BEHAVIOUR
//  Reset (async assert, sync-safe release): duty[*]=0, step=0, state IDLE, pwm_cnt=0,
//   busy=0, cmd_err=0, led_out = all-off (all 1s if ACTIVE_LOW else all 0s).
//  Commands (opcode byte in IDLE):
//   0x53 'S' : enter COLLECT, idx=0; next NUM_CH bytes are duty[0..NUM_CH-1]
//              (upper PWM_BITS bits of byte if PWM_BITS<8; zero-extended if >8).
//              Payload is staged; all duties update together on the cycle after the
//              last payload byte (atomic). Also sets step=0.
//   0x4E 'N' : step = (step==NUM_CH) ? 0 : step+1; duty[i] = all-ones for i<step, else 0.
//   0x4F 'O' : duty[*]=0, step=0.
//   other    : ignored, cmd_err pulses next cycle.
//   Opcode/payload takes effect on duty registers 1 cycle after rx_valid.
//  FSM: IDLE -(S)-> COLLECT; COLLECT -(last byte)-> IDLE (apply);
//   COLLECT -(timer==TIMEOUT_CYC-1, no rx_valid)-> IDLE, staged data discarded,
//   duties unchanged, cmd_err pulse. Timer clears on every accepted byte.
//  In COLLECT every byte is payload, including 0x53/0x4E/0x4F (no re-sync).
//  rx_valid in the same cycle timeout would fire: byte accepted, no timeout.
//  busy=1 exactly while state==COLLECT.
//  PWM: free-running pwm_cnt wraps 2**PWM_BITS-1 -> 0. on[i] = (pwm_cnt < duty[i]);
//   led_out registered (1 cycle after compare). duty 0 = never on; all-ones =
//   on (2**PWM_BITS-1) of 2**PWM_BITS cycles. Duty changes take effect immediately
//   (no wait for period boundary); glitch of one partial period accepted.
//  rst_n asserted mid-COLLECT: staged bytes lost, all state to reset values.
// TESTING (ACTIVE_LOW=0, PWM_BITS=8, NUM_CH=3, TIMEOUT_CYC=100 unless stated)
//  1 reset then idle 600 cycles -> led_out=3'b000 always, busy=0, cmd_err never.
//  2 'N' x4 -> channels on: {0},{0,1},{0,1,2},none; 5th 'N' -> {0} again (wrap).
//  3 'S',0x80,0x00,0xFF -> busy high between bytes; ch0 high 128/256, ch1 0/256,
//    ch2 255/256 per period; duties change only after 3rd payload byte.
//  4 'S',0x40 then silence 100 cycles -> cmd_err pulse, busy=0, prior duties kept.
//  5 byte 0x41 in IDLE -> single cmd_err pulse, outputs unchanged; 'O' -> all off.
//  6 rst_n low mid-'S' payload, release, send 'N' -> only ch0 on; ACTIVE_LOW=1
//    rerun of case 1 -> led_out=3'b111.

Source files
------------

// File: rtl/uart_led_pwm_ctrl.sv
// Byte-command LED controller: step toggle, atomic multi-byte duty load,
// per-channel PWM with selectable output polarity.
module uart_led_pwm_ctrl #(
    parameter int NUM_CH      = 3,
    parameter int PWM_BITS    = 8,
    parameter int TIMEOUT_CYC = 1200000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [NUM_CH-1:0] led_out,
    output logic              busy,
    output logic              cmd_err
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW = $clog2(NUM_CH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int SH = (PWM_BITS < 8) ? (8 - PWM_BITS) : 0;

    localparam logic [7:0] OP_SET  = 8'h53;
    localparam logic [7:0] OP_NEXT = 8'h4E;
    localparam logic [7:0] OP_OFF  = 8'h4F;

    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    localparam logic [NUM_CH-1:0]   LED_OFF  =
        (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PWM_BITS-1:0] r_duty  [NUM_CH];
    logic [PWM_BITS-1:0] r_stage [NUM_CH];
    logic [IW-1:0]       r_idx;
    logic [TW-1:0]       r_timer;
    logic [SW-1:0]       r_step;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_CH-1:0]   r_led;
    logic                r_cmd_err;

    logic                w_idle;
    logic                w_collect;
    logic                w_op_set;
    logic                w_op_next;
    logic                w_op_off;
    logic                w_op_bad;
    logic                w_pay;
    logic                w_last;
    logic                w_tmo;
    logic [SW-1:0]       w_step_inc;
    logic [PWM_BITS-1:0] w_byte_duty;
    logic [NUM_CH-1:0]   w_on;

    assign w_idle    = (r_state == S_IDLE);
    assign w_collect = (r_state == S_COLLECT);

    assign w_op_set  = w_idle && rx_valid && (rx_data == OP_SET);
    assign w_op_next = w_idle && rx_valid && (rx_data == OP_NEXT);
    assign w_op_off  = w_idle && rx_valid && (rx_data == OP_OFF);
    assign w_op_bad  = w_idle && rx_valid &&
                       !(w_op_set || w_op_next || w_op_off);

    // Every byte seen in COLLECT is payload, opcodes included.
    assign w_pay  = w_collect && rx_valid;
    assign w_last = w_pay && (r_idx == IW'(NUM_CH - 1));
    assign w_tmo  = w_collect && !rx_valid &&
                    (r_timer == TW'(TIMEOUT_CYC - 1));

    assign w_step_inc = (r_step == SW'(NUM_CH)) ? '0 : r_step + 1'b1;

    // Narrow duties keep the byte's MSBs; wide duties zero-extend it.
    assign w_byte_duty = PWM_BITS'(rx_data >> SH);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_op_set) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_last || w_tmo) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == S_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_timer <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (w_op_set) begin
            r_idx   <= '0;
            r_timer <= '0;
        end else if (w_pay) begin
            r_stage[r_idx] <= w_byte_duty;
            r_idx          <= r_idx + 1'b1;
            r_timer        <= '0;
        end else if (w_collect) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Duty registers: the set command commits all channels at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= '0;
            end
        end else if (w_op_set || w_op_off) begin
            r_step <= '0;
            if (w_op_off) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_duty[i] <= '0;
                end
            end
        end else if (w_op_next) begin
            r_step <= w_step_inc;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= (SW'(i) < w_step_inc) ? DUTY_MAX : '0;
            end
        end else if (w_last) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (i == NUM_CH - 1) begin
                    r_duty[i] <= w_byte_duty;
                end else begin
                    r_duty[i] <= r_stage[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    always_comb begin
        w_on = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_on[i] = (r_pwm_cnt < r_duty[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led     <= LED_OFF;
            r_cmd_err <= 1'b0;
        end else begin
            r_led     <= (ACTIVE_LOW != 0) ? ~w_on : w_on;
            r_cmd_err <= w_op_bad || w_tmo;
        end
    end

    assign led_out = r_led;
    assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_uart_led_pwm_ctrl.sv
// Randomized bench: duty per channel measured as on-cycles per PWM period,
// compared with a command-level model; both output polarities in parallel.
module tb_uart_led_pwm_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] led_hi;
    logic [2:0] led_lo;
    logic       busy;
    logic       busy_al;
    logic       cmd_err;
    logic       err_al;

    int n_chk;
    int n_err;
    int n_pulse;
    int n_pulse_al;
    int exp_pulse;
    int md[3];
    int mstep;

    uart_led_pwm_ctrl #(
        .NUM_CH(3), .PWM_BITS(8), .TIMEOUT_CYC(100), .ACTIVE_LOW(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .led_out(led_hi), .busy(busy), .cmd_err(cmd_err)
    );

    uart_led_pwm_ctrl #(
        .NUM_CH(3), .PWM_BITS(8), .TIMEOUT_CYC(100), .ACTIVE_LOW(1)
    ) u_dut_al (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .led_out(led_lo), .busy(busy_al), .cmd_err(err_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err) n_pulse++;
        if (err_al) n_pulse_al++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int w);
        repeat (w) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Single-byte command model
    task automatic model_cmd(input logic [7:0] b);
        case (b)
            8'h53: mstep = 0;
            8'h4E: begin
                mstep = (mstep == 3) ? 0 : mstep + 1;
                for (int i = 0; i < 3; i++) md[i] = (i < mstep) ? 255 : 0;
            end
            8'h4F: begin
                mstep = 0;
                for (int i = 0; i < 3; i++) md[i] = 0;
            end
            default: exp_pulse++;
        endcase
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(b, 0);
        model_cmd(b);
    endtask

    task automatic send_set(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input int w);
        cmd(8'h53);
        chk("busy after S", int'(busy), 1);
        send_byte(p0, w);
        chk("busy pay0", int'(busy), 1);
        send_byte(p1, w);
        chk("busy pay1", int'(busy_al), 1);
        send_byte(p2, w);
        chk("busy done", int'(busy), 0);
        md[0] = int'(p0);
        md[1] = int'(p1);
        md[2] = int'(p2);
    endtask

    task automatic measure(input string tag);
        int hi[3];
        int lo[3];
        for (int i = 0; i < 3; i++) begin
            hi[i] = 0;
            lo[i] = 0;
        end
        repeat (2) @(negedge clk);
        repeat (256) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (led_hi[i]) hi[i]++;
                if (!led_lo[i]) lo[i]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s ch%0d", tag, i), hi[i], md[i]);
            chk($sformatf("%s al ch%0d", tag, i), lo[i], md[i]);
        end
        chk($sformatf("%s err", tag), n_pulse, exp_pulse);
        chk($sformatf("%s al err", tag), n_pulse_al, exp_pulse);
    endtask

    initial begin
        int bad;
        int cnt;
        logic [7:0] b;
        n_chk = 0;
        n_err = 0;
        n_pulse = 0;
        n_pulse_al = 0;
        exp_pulse = 0;
        mstep = 0;
        for (int i = 0; i < 3; i++) md[i] = 0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        rst_n = 1'b0;

        repeat (4) @(negedge clk);
        chk("rst led", int'(led_hi), 0);
        chk("rst led al", int'(led_lo), 7);
        chk("rst busy", int'(busy), 0);
        rst_n = 1'b1;

        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (led_hi != 3'b000 || led_lo != 3'b111) bad++;
            if (busy || busy_al || cmd_err || err_al) bad++;
        end
        chk("idle 600", bad, 0);

        for (int k = 0; k < 5; k++) begin
            cmd(8'h4E);
            measure($sformatf("N%0d", k));
        end

        send_set(8'h80, 8'h00, 8'hFF, 5);
        measure("S 80 00 FF");

        cmd(8'h53);
        send_byte(8'h40, 0);
        chk("tmo busy", int'(busy), 1);
        cnt = 0;
        while (!cmd_err && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        exp_pulse++;
        chk("tmo latency", cnt, 100);
        @(negedge clk);
        chk("tmo busy clr", int'(busy), 0);
        measure("tmo keep");

        send_set(8'h4E, 8'h53, 8'h4F, 98);
        measure("S edge gap");

        cmd(8'h41);
        measure("bad op");
        cmd(8'h4F);
        measure("O");

        cmd(8'h53);
        send_byte(8'h11, 3);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst led al", int'(led_lo), 7);
        rst_n = 1'b1;
        mstep = 0;
        for (int i = 0; i < 3; i++) md[i] = 0;
        cmd(8'h4E);
        measure("post rst N");

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: cmd(8'h4E);
                1: cmd(8'h4F);
                2: send_set(8'($urandom), 8'($urandom), 8'($urandom),
                            $urandom_range(0, 98));
                default: begin
                    do b = 8'($urandom_range(0, 255));
                    while (b == 8'h53 || b == 8'h4E || b == 8'h4F);
                    cmd(b);
                end
            endcase
            measure($sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
